ows_rx_decoder: RTL and testbench
=================================

OWS_RX_DECODER -- requirements
Module: ows_rx_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per received word (1..32).
REQ-002 SHALL have parameter T_ONE_MIN, default 500, low-phase cycle count above which a pulse is a '1'.
REQ-003 SHALL have parameter T_ZERO_MIN, default 1500, low-phase cycle count above which a pulse is a '0'.
REQ-004 SHALL have parameter T_RST_MIN, default 23950, low-phase cycle count above which a pulse is a bus reset.
REQ-005 SHALL have parameter SYNC_STAGES, default 2, number of input synchroniser flops (2..3).
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port data_in, input, 1, asynchronous 1-wire bus level.
REQ-009 SHALL have port abort, input, 1, synchronous abandon of the current word.
REQ-010 SHALL have port data_out, output, DATA_WIDTH, received word.
REQ-011 SHALL have port data_valid, output, 1, data_out holds an unconsumed word.
REQ-012 SHALL have port data_ready, input, 1, consumer accepts data_out.
REQ-013 SHALL have port reset_det, output, 1, one-cycle pulse on detected bus reset.
REQ-014 SHALL have port frame_err, output, 1, one-cycle pulse on a too-short low pulse.
REQ-015 SHALL have port overrun, output, 1, one-cycle pulse when a completed word is dropped.
REQ-016 SHALL have port busy, output, 1, high while a word is partially received (bit count non-zero or state LOW).

Function
REQ-017 SHALL pass data_in through SYNC_STAGES flops, giving din_s, before any use.
REQ-018 SHALL implement states IDLE (wait for din_s=1), ARMED (bus high, wait for din_s=0), LOW (count low cycles).
REQ-019 SHALL move IDLE->ARMED when din_s=1; ARMED->LOW on din_s=0, loading low counter with 1.
REQ-020 SHALL, in LOW, increment the counter each cycle din_s=0, saturating at all-ones; width is clog2(T_RST_MIN+2).
REQ-021 SHALL classify on the first LOW cycle with din_s=1 and return to ARMED in that same cycle.
REQ-022 SHALL classify using strict comparisons, in priority order: cnt>T_RST_MIN -> reset; cnt>T_ZERO_MIN -> bit 0; cnt>T_ONE_MIN -> bit 1; otherwise -> frame error.
REQ-023 SHALL shift received bits LSB first into a DATA_WIDTH shift register and count them.
REQ-024 SHALL, on the DATA_WIDTH-th bit, register the word to data_out, assert data_valid on the next cycle, and clear the bit count.
REQ-025 SHALL give latency of SYNC_STAGES+1 clk cycles from the data_in rising edge to data_valid high.
REQ-026 SHALL hold data_out and data_valid stable until a cycle with data_valid=1 and data_ready=1; data_valid falls on the following cycle.
REQ-027 SHALL, on a word completing while data_valid=1 and data_ready=0, drop the new word, keep the old one, and pulse overrun.
REQ-028 SHALL, on a word completing in the same cycle as a handshake, load the new word with data_valid remaining 1 and no overrun.
REQ-029 SHALL, on a reset classification, pulse reset_det and clear the shift register and bit count; the held data_out/data_valid are unaffected.
REQ-030 SHALL, on a frame-error classification, pulse frame_err and clear the bit count (partial word discarded).
REQ-031 SHALL, on abort=1, go to IDLE and clear counter, bit count and shift register within the same cycle; the output word is kept; abort overrides a classification in that cycle.

Reset
REQ-032 SHALL, on rst_n low, asynchronously set: state IDLE, sync flops 1, counters 0, data_out 0, data_valid 0, reset_det 0, frame_err 0, overrun 0, busy 0.
REQ-033 SHALL release reset synchronously via the rst_n deassertion edge only; after release, no classification occurs until a full high->low->high pulse is seen.

Structure
REQ-034 SHALL place the state encoding, default timing thresholds and counter-width function in package ows_pkg.
REQ-035 SHALL instantiate one sub-module, ows_sync, implementing the synchroniser and rise/fall edge detection on din_s.

Verification
REQ-036 SHALL cover: byte 0xA5 sent LSB first as low pulses of 1000/2000 cycles (1,0,1,0,0,1,0,1) with data_ready=1 -> data_out=0xA5, data_valid high for 1 cycle.
REQ-037 SHALL cover: a 24000-cycle low pulse after 3 bits, then 0x3C -> reset_det pulse, data_out=0x3C, no frame_err.
REQ-038 SHALL cover: a 100-cycle glitch after 4 bits, then 8 valid bits 0xFF -> one frame_err pulse, data_out=0xFF.
REQ-039 SHALL cover: 0x11 then 0x22 with data_ready=0 -> data_out=0x11, one overrun pulse; next handshake clears data_valid.
REQ-040 SHALL cover: boundary pulses of 500, 501, 1500, 1501 cycles -> frame_err, '1', '1', '0' respectively.
REQ-041 SHALL cover: rst_n low mid-word and abort mid-word -> outputs at reset values / partial word discarded; the next full byte is received correctly.

Source files
------------

// File: rtl/ows_pkg.sv
// Shared definitions for the 1-wire style pulse-width receiver: FSM state
// encoding, pulse classification results, default timing thresholds and the
// low-phase counter width helper.
package ows_pkg;

  // Receiver FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for the bus to be seen high
    ST_ARMED = 2'd1,  // bus high, waiting for the next falling edge
    ST_LOW   = 2'd2   // bus low, counting low-phase cycles
  } ows_state_e;

  // Meaning of a completed low pulse, judged from its length.
  typedef enum logic [1:0] {
    CLS_ERR  = 2'd0,  // too short to be a bit
    CLS_ONE  = 2'd1,
    CLS_ZERO = 2'd2,
    CLS_RST  = 2'd3   // long enough to be a bus reset
  } ows_class_e;

  // Default word size and timing thresholds, in clk cycles of low phase.
  localparam int OWS_DATA_WIDTH  = 8;
  localparam int OWS_T_ONE_MIN   = 500;
  localparam int OWS_T_ZERO_MIN  = 1500;
  localparam int OWS_T_RST_MIN   = 23950;
  localparam int OWS_SYNC_STAGES = 2;

  // The low counter must represent T_RST_MIN+1 (the shortest reset pulse)
  // without saturating, so it needs clog2(T_RST_MIN+2) bits.
  function automatic int ows_cnt_width(input int t_rst_min);
    return $clog2(t_rst_min + 2);
  endfunction

endpackage

// File: rtl/ows_sync.sv
// Input synchroniser for the asynchronous bus level, plus single-cycle
// rise/fall strobes on the synchronised level.
module ows_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic data_in,
  output logic din_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   din_prev_q;

  // Shift the raw bus level through the synchroniser and remember the last
  // synchronised value for edge detection.
  // NOTE: the flops reset to 1 (idle bus level) so leaving reset never looks
  // like a falling edge on a bus that is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '1;
      din_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], data_in};
      din_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign din_s = sync_q[SYNC_STAGES-1];
  assign rise  = din_s & ~din_prev_q;
  assign fall  = ~din_s & din_prev_q;

endmodule

// File: rtl/ows_rx_decoder.sv
// Pulse-width decoder for a 1-wire style bus. Each low pulse on the bus is
// measured and classified as a '1', a '0', a bus reset or a framing error.
// Bits are assembled LSB first into DATA_WIDTH-bit words presented on a
// valid/ready output; a word that completes while the previous one is still
// unconsumed is dropped and flagged as an overrun.
module ows_rx_decoder
  import ows_pkg::*;
#(
  parameter int DATA_WIDTH  = OWS_DATA_WIDTH,
  parameter int T_ONE_MIN   = OWS_T_ONE_MIN,
  parameter int T_ZERO_MIN  = OWS_T_ZERO_MIN,
  parameter int T_RST_MIN   = OWS_T_RST_MIN,
  parameter int SYNC_STAGES = OWS_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_in,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  reset_det,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int CW = ows_cnt_width(T_RST_MIN);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  localparam logic [CW-1:0] CNT_ONE_MIN  = CW'(T_ONE_MIN);
  localparam logic [CW-1:0] CNT_ZERO_MIN = CW'(T_ZERO_MIN);
  localparam logic [CW-1:0] CNT_RST_MIN  = CW'(T_RST_MIN);
  localparam logic [BW-1:0] BIT_LAST     = BW'(DATA_WIDTH - 1);

  // Synchronised bus level and its edges.
  logic din_s;
  logic rise;
  logic fall;

  ows_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .din_s   (din_s),
    .rise    (rise),
    .fall    (fall)
  );

  ows_state_e            state_q,   state_d;
  logic [CW-1:0]         cnt_q,     cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q,   shreg_d;
  logic [DATA_WIDTH-1:0] data_q,    data_d;
  logic                  valid_q,   valid_d;
  logic                  rst_det_q, rst_det_d;
  logic                  ferr_q,    ferr_d;
  logic                  ovr_q,     ovr_d;

  ows_class_e            cls;
  logic [DATA_WIDTH-1:0] shifted;

  // Judge the pulse length held in the low counter; longest class wins.
  always_comb begin
    if (cnt_q > CNT_RST_MIN) begin
      cls = CLS_RST;
    end else if (cnt_q > CNT_ZERO_MIN) begin
      cls = CLS_ZERO;
    end else if (cnt_q > CNT_ONE_MIN) begin
      cls = CLS_ONE;
    end else begin
      cls = CLS_ERR;
    end
  end

  // Shift register contents after accepting the bit just classified; new
  // bits enter at the top so the first bit received ends up in bit 0.
  always_comb begin
    shifted                 = shreg_q >> 1;
    shifted[DATA_WIDTH-1]   = (cls == CLS_ONE);
  end

  // Next-state logic: pulse measurement, bit assembly and output handshake.
  // NOTE: every _d signal takes its hold value first so no path through the
  // block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = valid_q & ~data_ready;
    rst_det_d = 1'b0;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;

    if (abort) begin
      // Abandon the word in flight; the held output word is untouched.
      state_d   = ST_IDLE;
      cnt_d     = '0;
      bit_cnt_d = '0;
      shreg_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (din_s) begin
            state_d = ST_ARMED;
          end
        end

        ST_ARMED: begin
          if (fall) begin
            state_d = ST_LOW;
            cnt_d   = CW'(1);
          end
        end

        ST_LOW: begin
          if (rise) begin
            state_d = ST_ARMED;
            case (cls)
              CLS_RST: begin
                rst_det_d = 1'b1;
                shreg_d   = '0;
                bit_cnt_d = '0;
              end
              CLS_ERR: begin
                ferr_d    = 1'b1;
                bit_cnt_d = '0;
              end
              default: begin
                shreg_d = shifted;
                if (bit_cnt_q == BIT_LAST) begin
                  bit_cnt_d = '0;
                  // The slot is free if empty or being consumed this cycle.
                  if (!valid_q || data_ready) begin
                    data_d  = shifted;
                    valid_d = 1'b1;
                  end else begin
                    ovr_d = 1'b1;
                  end
                end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
                end
              end
            endcase
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      rst_det_q <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      rst_det_q <= rst_det_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign reset_det  = rst_det_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (bit_cnt_q != '0) || (state_q == ST_LOW);

endmodule

// File: tb/tb_ows_rx_decoder.sv
// Scoreboard bench for ows_rx_decoder. Timing thresholds are scaled down by
// ten from the defaults so long pulses stay short in cycles.
module tb_ows_rx_decoder;

  localparam int DW       = 8;
  localparam int T1       = 50;
  localparam int T0       = 150;
  localparam int TR       = 2395;
  localparam int SS       = 2;
  localparam int ONE_LEN  = 100;
  localparam int ZERO_LEN = 200;
  localparam int RST_LEN  = 2400;
  localparam int GAP      = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          data_in = 1'b1;
  logic          abort = 1'b0;
  logic          data_ready = 1'b1;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          reset_det;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  always #5 clk = ~clk;

  ows_rx_decoder #(
    .DATA_WIDTH  (DW),
    .T_ONE_MIN   (T1),
    .T_ZERO_MIN  (T0),
    .T_RST_MIN   (TR),
    .SYNC_STAGES (SS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .abort      (abort),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .reset_det  (reset_det),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: received bits of the current word, expected
  // words, expected event counts.
  int exp_q[$];
  int mbits[$];
  bit model_pending = 1'b0;
  int exp_rst = 0, exp_ferr = 0, exp_ovr = 0;
  int obs_rst = 0, obs_ferr = 0, obs_ovr = 0;
  bit prev_hs = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A finished word is either accepted or, if the previous one is still
  // unconsumed, lost as an overrun.
  function automatic void model_deliver(input int word);
    if (model_pending) begin
      exp_ovr++;
    end else begin
      exp_q.push_back(word);
      if (!data_ready) model_pending = 1'b1;
    end
  endfunction

  function automatic void model_pulse(input int low);
    int word;
    if (low > TR) begin
      exp_rst++;
      mbits.delete();
    end else if (low > T0) begin
      mbits.push_back(0);
    end else if (low > T1) begin
      mbits.push_back(1);
    end else begin
      exp_ferr++;
      mbits.delete();
    end
    if (mbits.size() == DW) begin
      word = 0;
      foreach (mbits[i]) word += mbits[i] << i;
      mbits.delete();
      model_deliver(word);
    end
  endfunction

  // Drive one low pulse followed by a high gap; optionally measure the
  // cycles from the rising edge to data_valid.
  task automatic send_pulse(input int low, input int high, input bit measure);
    int k;
    bit seen;
    data_in = 1'b0;
    repeat (low) @(posedge clk);
    #1;
    model_pulse(low);
    data_in = 1'b1;
    if (measure) begin
      k = 0;
      seen = 1'b0;
      while (!seen && k < 10) begin
        @(posedge clk);
        k++;
        #1;
        if (data_valid) seen = 1'b1;
      end
      check("latency_cycles", k, SS + 1);
      repeat (high - k) @(posedge clk);
      #1;
    end else begin
      repeat (high) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input bit measure_last);
    for (int i = 0; i < n; i++) begin
      if (measure_last && i == n - 1)
        send_pulse(v[i] ? ONE_LEN : ZERO_LEN, 12, 1'b1);
      else
        send_pulse(v[i] ? ONE_LEN : ZERO_LEN, GAP, 1'b0);
    end
  endtask

  task automatic send_bits_rand(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      send_pulse(v[i] ? $urandom_range(60, 140) : $urandom_range(160, 400),
                 $urandom_range(3, 20), 1'b0);
    end
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_reset_det_cnt"}, obs_rst, exp_rst);
    check({tag, "_frame_err_cnt"}, obs_ferr, exp_ferr);
    check({tag, "_overrun_cnt"}, obs_ovr, exp_ovr);
    check({tag, "_words_left"}, exp_q.size(), 0);
  endtask

  // Monitor: counts pulse outputs and compares every handshaken word
  // against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) check("valid_drop_after_hs", data_valid, 1'b0);
      prev_hs = 1'b0;
      if (reset_det) obs_rst++;
      if (frame_err) obs_ferr++;
      if (overrun)   obs_ovr++;
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_word: got 0x%0h expected none at %0t", data_out, $time);
        end else begin
          check("data_out", data_out, exp_q.pop_front());
        end
        prev_hs = 1'b1;
      end
    end
  end

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", data_out, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_reset_det", reset_det, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // 0xA5 with the consumer always ready; latency measured on the last bit.
    send_bits(32'hA5, 8, 1'b1);
    settle();
    check_counts("a5");

    // Bus reset after three bits discards them; 0x3C follows cleanly.
    send_bits(32'h5, 3, 1'b0);
    send_pulse(RST_LEN, GAP, 1'b0);
    send_bits(32'h3C, 8, 1'b0);
    settle();
    check_counts("busrst");

    // Short glitch after four bits is a framing error.
    send_bits(32'hA, 4, 1'b0);
    send_pulse(10, GAP, 1'b0);
    send_bits(32'hFF, 8, 1'b0);
    settle();
    check_counts("glitch");

    // Consumer stalled: second word overruns, first is held.
    data_ready = 1'b0;
    send_bits(32'h11, 8, 1'b0);
    send_bits(32'h22, 8, 1'b0);
    settle();
    check("ovr_held_word", data_out, exp_q[0]);
    check("ovr_held_valid", data_valid, 1'b1);
    check("ovr_count", obs_ovr, exp_ovr);
    data_ready = 1'b1;
    model_pending = 1'b0;
    settle();
    check("ovr_valid_cleared", data_valid, 1'b0);
    check_counts("overrun");

    // Threshold boundaries: 50 err, 51 one, 150 one, 151 zero.
    send_pulse(50, GAP, 1'b0);
    send_pulse(51, GAP, 1'b0);
    send_pulse(150, GAP, 1'b0);
    send_pulse(151, GAP, 1'b0);
    check("busy_partial", busy, mbits.size() != 0);
    send_bits(32'h16, 5, 1'b0);
    settle();
    check_counts("boundary");

    // Reset asserted mid-word.
    send_bits(32'h3, 3, 1'b0);
    rst_n = 1'b0;
    mbits.delete();
    repeat (2) @(posedge clk);
    #1;
    check("midrst_data_out", data_out, 0);
    check("midrst_valid", data_valid, 0);
    check("midrst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send_bits(32'h96, 8, 1'b0);
    settle();
    check_counts("midrst");

    // Abort during a low phase: no classification of that pulse.
    send_bits(32'h9, 4, 1'b0);
    data_in = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("abort_busy_before", busy, 1'b1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    mbits.delete();
    check("abort_busy_after", busy, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    data_in = 1'b1;
    settle();
    check("abort_busy_idle", busy, 1'b0);
    check_counts("abort_low");

    // Abort during a high gap.
    send_bits(32'h2, 3, 1'b0);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    mbits.delete();
    send_bits(32'h5A, 8, 1'b0);
    settle();
    check_counts("abort_high");

    // Randomised words with randomised pulse and gap lengths.
    for (int w = 0; w < 12; w++) begin
      send_bits_rand($urandom_range(0, 255), 8);
    end
    settle();
    check_counts("random");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
